stage_if: RTL and testbench
===========================

Name: stage_if

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of stage_id. It owns the PC and issues held-request reads to instruction ROM. It delivers {register_pc, instruction, valid} into the IF/ID output registers consumed by stage_id. It handles downstream stalls with a one-entry hold buffer, branch redirects with MIPS delay-slot semantics, and flushes that kill in-flight fetches.

Parameters:
RESET_VECTOR, 32'h0000_0000, first fetch address after reset
NOP_WORD, 32'h0000_0000, instruction value driven when valid=0

Ports:
clock  in  1  sole clock; all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  stage_id cannot accept a new instruction this cycle
branch_enable  in  1  stage_id resolved a taken branch/jump (qualified by stall=0)
branch_address  in  32  branch/jump target
flush_enable  in  1  exception/flush redirect; highest priority
flush_address  in  32  flush target
rom_read_enable  out  1  read request, held high until rom_ready
rom_address  out  32  request address, stable while request outstanding
rom_read_data  in  32  instruction word, valid when rom_ready=1
rom_ready  in  1  response strobe; only meaningful while rom_read_enable=1
register_pc  out  32  PC of delivered instruction (to stage_id)
instruction  out  32  delivered instruction (to stage_id)
valid  out  1  output registers hold a real instruction

Behaviour:
- Reset, synchronous: state=REQ, pc=RESET_VECTOR, req_pc=RESET_VECTOR, kill=0, tgt_pending=0, valid=0, instruction=NOP_WORD, register_pc=0.
- Reset mid-request abandons the request. The ROM must tolerate the rom_read_enable drop.
- States: REQ (request outstanding) and HOLD (word captured, stage_id stalled).
- REQ: rom_read_enable=1, rom_address=req_pc.
  - req_pc changes only on the edge where rom_ready=1 is sampled, or on reset.
- Delivery loads the IF/ID output registers: valid=1, instruction=word, register_pc=delivered pc.
  - Next pc = branch_address if branch_enable this cycle.
  - Otherwise next pc = saved target if tgt_pending, and tgt_pending is cleared.
  - Otherwise next pc = pc+4, mod 2^32, wrapping silently.
  - req_pc takes next pc.
- REQ, rom_ready=1, kill=0, stall=0: deliver rom_read_data and stay in REQ.
  - Latency: request issued in cycle N with ready in N gives valid at N+1.
  - Throughput is 1 instruction/cycle at zero-wait ROM.
- REQ, rom_ready=1, kill=0, stall=1: capture the word into hold_buf, go to HOLD; outputs unchanged.
- REQ, rom_ready=1, kill=1: discard the word, kill=0, req_pc=pc, stay in REQ.
- REQ, rom_ready=0: keep requesting. Outputs hold if stall=1; otherwise valid=0 and instruction=NOP_WORD (bubble).
- HOLD: rom_read_enable=0.
  - If stall=0, deliver hold_buf, go to REQ, and request next pc the following cycle.
  - If stall=1, hold.
- Branch (branch_enable=1, stall=0, flush_enable=0):
  - The branch is in stage_id; the next instruction delivered is the delay slot and is kept.
  - If delivery happens the same cycle, next pc=branch_address directly.
  - Otherwise latch target, tgt_pending=1.
  - branch_enable is ignored while stall=1.
- Flush (flush_enable=1, regardless of stall/branch):
  - pc=flush_address, tgt_pending=0, valid=0, instruction=NOP_WORD.
  - In HOLD: drop hold_buf, state=REQ, req_pc=flush_address.
  - In REQ: if rom_ready=1 this cycle, discard the word and req_pc=flush_address; else kill=1.
- Simultaneous flush + branch: flush wins. Flush + stall: flush wins, and the output bubble is required.
- stall=1 with valid=1 never alters register_pc or instruction.

Decomposition:
- Shared include cpu_defines.vh: state encodings (IF_REQ, IF_HOLD), NOP_WORD, RESET_VECTOR. stage_id reuses NOP_WORD.
- No sub-module. hold_buf is a 64-bit register inline; pc and kill logic are too small to split.

Test Plan:
1. Reset, then rom_ready tied 1, stall=0 -> rom_address 0,4,8,C. valid rises 1 cycle after reset release; register_pc 0,4,8 with matching instructions.
2. Ready in cycle N while stall=1 for 3 cycles -> state HOLD, rom_read_enable=0, outputs frozen. On stall release, the buffered word at pc 0x8 appears next cycle, then a request to 0xC.
3. branch_enable with branch_address=0x100 while a fetch of 0x8 waits 2 cycles for ready -> 0x8 delivered (delay slot), next rom_address=0x100, then 0x104.
4. flush_address=0x80 asserted with a request to 0x10 outstanding, ready after 3 cycles -> valid=0 throughout, word for 0x10 never delivered. Next request 0x80, delivered with register_pc=0x80.
5. flush_enable and branch_enable in the same cycle, with flush 0x80 and branch 0x200 -> stream resumes at 0x80; 0x200 never requested.
6. Reset asserted mid-request and mid-HOLD -> next cycle valid=0, instruction=NOP_WORD, rom_address=RESET_VECTOR; no stale word is delivered.

Source files
------------

// File: rtl/stage_if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package stage_if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP      = 32'd4;

    // REQ: ROM request outstanding; HOLD: word parked while stage_id stalls
    typedef enum logic {
        IF_REQ  = 1'b0,
        IF_HOLD = 1'b1
    } if_state_e;

    // One fetched instruction together with the pc it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    // Sequential successor, wrapping silently at 2^32
    function automatic logic [XLEN-1:0] pc_seq_next(input logic [XLEN-1:0] pc);
        return XLEN'(pc + PC_STEP);
    endfunction

endpackage

// File: rtl/stage_if_if.sv
// Fetch-stage bus: pipeline control from stage_id, ROM handshake, IF/ID payload.
interface stage_if_if;
    import stage_if_pkg::*;

    logic            stall;
    logic            branch_enable;
    logic [XLEN-1:0] branch_address;
    logic            flush_enable;
    logic [XLEN-1:0] flush_address;

    logic            rom_read_enable;
    logic [XLEN-1:0] rom_address;
    logic [XLEN-1:0] rom_read_data;
    logic            rom_ready;

    logic [XLEN-1:0] register_pc;
    logic [XLEN-1:0] instruction;
    logic            valid;

    // Fetch stage side
    modport master (
        input  stall, branch_enable, branch_address, flush_enable, flush_address,
        input  rom_read_data, rom_ready,
        output rom_read_enable, rom_address,
        output register_pc, instruction, valid
    );

    // Environment side (stage_id + instruction ROM)
    modport slave (
        output stall, branch_enable, branch_address, flush_enable, flush_address,
        output rom_read_data, rom_ready,
        input  rom_read_enable, rom_address,
        input  register_pc, instruction, valid
    );

endinterface

// File: rtl/stage_if.sv
// Instruction-fetch stage: owns the PC, issues held ROM requests, delivers
// {register_pc, instruction, valid} to stage_id with stall, branch delay-slot
// and flush handling.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR_P = RESET_VECTOR,
    parameter logic [31:0] NOP_WORD_P     = NOP_WORD
) (
    input  logic         clock,
    input  logic         reset,
    stage_if_if.master   bus
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            kill_q, kill_d;
    logic            tgt_pending_q, tgt_pending_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    fetch_entry_t    hold_buf_q, hold_buf_d;
    logic            rom_read_enable_q, rom_read_enable_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instruction_q, instruction_d;
    logic [XLEN-1:0] register_pc_q, register_pc_d;

    logic            branch_take;
    logic            deliver;
    fetch_entry_t    deliver_entry;
    logic [XLEN-1:0] next_pc;

    // Next-state, pc sequencing and IF/ID payload selection
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        req_pc_d          = req_pc_q;
        kill_d            = kill_q;
        tgt_pending_d     = tgt_pending_q;
        tgt_d             = tgt_q;
        hold_buf_d        = hold_buf_q;
        valid_d           = valid_q;
        instruction_d     = instruction_q;
        register_pc_d     = register_pc_q;
        deliver           = 1'b0;
        deliver_entry     = '0;
        next_pc           = pc_q;
        branch_take       = bus.branch_enable && !bus.stall;

        if (bus.flush_enable) begin
            // Flush beats branch and stall; the output bubble is mandatory
            pc_d          = bus.flush_address;
            tgt_pending_d = 1'b0;
            valid_d       = 1'b0;
            instruction_d = NOP_WORD_P;
            if (state_q == IF_HOLD) begin
                state_d  = IF_REQ;
                req_pc_d = bus.flush_address;
                kill_d   = 1'b0;
            end else if (bus.rom_ready) begin
                req_pc_d = bus.flush_address;
                kill_d   = 1'b0;
            end else begin
                // Request address must stay stable; drop its word when it lands
                kill_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                IF_REQ: begin
                    if (bus.rom_ready && kill_q) begin
                        kill_d   = 1'b0;
                        req_pc_d = pc_q;
                        if (!bus.stall) begin
                            valid_d       = 1'b0;
                            instruction_d = NOP_WORD_P;
                        end
                        if (branch_take) begin
                            tgt_d         = bus.branch_address;
                            tgt_pending_d = 1'b1;
                        end
                    end else if (bus.rom_ready && !bus.stall) begin
                        deliver       = 1'b1;
                        deliver_entry = '{pc: pc_q, word: bus.rom_read_data};
                    end else if (bus.rom_ready) begin
                        hold_buf_d = '{pc: pc_q, word: bus.rom_read_data};
                        state_d    = IF_HOLD;
                    end else begin
                        if (!bus.stall) begin
                            valid_d       = 1'b0;
                            instruction_d = NOP_WORD_P;
                        end
                        if (branch_take) begin
                            tgt_d         = bus.branch_address;
                            tgt_pending_d = 1'b1;
                        end
                    end
                end
                IF_HOLD: begin
                    if (!bus.stall) begin
                        deliver       = 1'b1;
                        deliver_entry = hold_buf_q;
                        state_d       = IF_REQ;
                    end
                end
                default: state_d = IF_REQ;
            endcase

            if (deliver) begin
                valid_d       = 1'b1;
                instruction_d = deliver_entry.word;
                register_pc_d = deliver_entry.pc;
                if (branch_take) begin
                    next_pc = bus.branch_address;
                end else if (tgt_pending_q) begin
                    next_pc       = tgt_q;
                    tgt_pending_d = 1'b0;
                end else begin
                    next_pc = pc_seq_next(deliver_entry.pc);
                end
                pc_d     = next_pc;
                req_pc_d = next_pc;
            end
        end

        rom_read_enable_d = (state_d == IF_REQ);
    end

    // State and IF/ID registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= IF_REQ;
            pc_q              <= RESET_VECTOR_P;
            req_pc_q          <= RESET_VECTOR_P;
            kill_q            <= 1'b0;
            tgt_pending_q     <= 1'b0;
            tgt_q             <= '0;
            hold_buf_q        <= '0;
            rom_read_enable_q <= 1'b1;
            valid_q           <= 1'b0;
            instruction_q     <= NOP_WORD_P;
            register_pc_q     <= '0;
        end else begin
            state_q           <= state_d;
            pc_q              <= pc_d;
            req_pc_q          <= req_pc_d;
            kill_q            <= kill_d;
            tgt_pending_q     <= tgt_pending_d;
            tgt_q             <= tgt_d;
            hold_buf_q        <= hold_buf_d;
            rom_read_enable_q <= rom_read_enable_d;
            valid_q           <= valid_d;
            instruction_q     <= instruction_d;
            register_pc_q     <= register_pc_d;
        end
    end

    assign bus.rom_read_enable = rom_read_enable_q;
    assign bus.rom_address     = req_pc_q;
    assign bus.valid           = valid_q;
    assign bus.instruction     = instruction_q;
    assign bus.register_pc     = register_pc_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: sequencing, stall/HOLD, branch delay slot,
// flush kill, flush priority, pc wrap and mid-request/mid-HOLD reset.
module tb_stage_if;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    stage_if_if bus ();

    stage_if #(
        .RESET_VECTOR_P (32'h0000_0000),
        .NOP_WORD_P     (32'h0000_0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM contents: distinct non-zero word per address
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign bus.rom_read_data = word_of(bus.rom_address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Instruction at pc delivered, next request to addr
    task automatic exp_dlv(input string tag, input logic [31:0] pc, input logic [31:0] addr);
        chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
        chk({tag, ".pc"},    bus.register_pc, pc);
        chk({tag, ".instr"}, bus.instruction, word_of(pc));
        chk({tag, ".ren"},   32'(bus.rom_read_enable), 32'd1);
        chk({tag, ".addr"},  bus.rom_address, addr);
    endtask

    // Bubble on the outputs, request to addr outstanding
    task automatic exp_bub(input string tag, input logic [31:0] addr);
        chk({tag, ".valid"}, 32'(bus.valid), 32'd0);
        chk({tag, ".instr"}, bus.instruction, 32'h0000_0000);
        chk({tag, ".ren"},   32'(bus.rom_read_enable), 32'd1);
        chk({tag, ".addr"},  bus.rom_address, addr);
    endtask

    // HOLD: outputs frozen on pc, no ROM request
    task automatic exp_hold(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(bus.valid), 32'd1);
        chk({tag, ".pc"},    bus.register_pc, pc);
        chk({tag, ".instr"}, bus.instruction, word_of(pc));
        chk({tag, ".ren"},   32'(bus.rom_read_enable), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.branch_enable  = 1'b0;
        bus.branch_address = 32'h0;
        bus.flush_enable   = 1'b0;
        bus.flush_address  = 32'h0;
        bus.rom_ready      = 1'b1;

        // Reset state
        tick();
        exp_bub("rst", 32'h0);
        chk("rst.pc", bus.register_pc, 32'h0);

        // Zero-wait sequential fetch
        reset = 1'b0;
        tick(); exp_dlv("seq0", 32'h0, 32'h4);
        tick(); exp_dlv("seq1", 32'h4, 32'h8);
        tick(); exp_dlv("seq2", 32'h8, 32'hC);

        // Stall for 3 cycles while the word for 0xC arrives
        bus.stall = 1'b1;
        tick(); exp_hold("hold0", 32'h8);
        tick(); exp_hold("hold1", 32'h8);
        tick(); exp_hold("hold2", 32'h8);
        bus.stall = 1'b0;
        tick(); exp_dlv("hold_rel", 32'hC, 32'h10);

        // Branch while fetch of 0x10 waits: 0x10 is the delay slot
        bus.rom_ready = 1'b0;
        tick(); exp_bub("br_wait0", 32'h10);
        bus.branch_enable  = 1'b1;
        bus.branch_address = 32'h100;
        tick(); exp_bub("br_wait1", 32'h10);
        bus.branch_enable = 1'b0;
        bus.rom_ready     = 1'b1;
        tick(); exp_dlv("br_slot", 32'h10, 32'h100);
        tick(); exp_dlv("br_tgt", 32'h100, 32'h104);

        // Branch resolved in a delivering cycle redirects directly
        bus.branch_enable  = 1'b1;
        bus.branch_address = 32'h40;
        tick(); exp_dlv("br_direct", 32'h104, 32'h40);
        bus.branch_enable = 1'b0;
        tick(); exp_dlv("br_direct_tgt", 32'h40, 32'h44);

        // Branch ignored while stalled
        bus.stall          = 1'b1;
        bus.branch_enable  = 1'b1;
        bus.branch_address = 32'h999;
        tick(); exp_hold("br_stall", 32'h40);
        bus.stall         = 1'b0;
        bus.branch_enable = 1'b0;
        tick(); exp_dlv("br_stall_rel", 32'h44, 32'h48);

        // Flush with a request outstanding: word for 0x48 is killed
        bus.rom_ready     = 1'b0;
        bus.flush_enable  = 1'b1;
        bus.flush_address = 32'h80;
        tick(); exp_bub("fl_k0", 32'h48);
        bus.flush_enable = 1'b0;
        tick(); exp_bub("fl_k1", 32'h48);
        tick(); exp_bub("fl_k2", 32'h48);
        bus.rom_ready = 1'b1;
        tick(); exp_bub("fl_discard", 32'h80);
        tick(); exp_dlv("fl_tgt", 32'h80, 32'h84);

        // Flush and branch together: flush wins
        bus.flush_enable   = 1'b1;
        bus.flush_address  = 32'h80;
        bus.branch_enable  = 1'b1;
        bus.branch_address = 32'h200;
        tick(); exp_bub("flbr", 32'h80);
        bus.flush_enable  = 1'b0;
        bus.branch_enable = 1'b0;
        tick(); exp_dlv("flbr_d0", 32'h80, 32'h84);
        tick(); exp_dlv("flbr_d1", 32'h84, 32'h88);

        // Flush with stall: bubble still required
        bus.stall         = 1'b1;
        bus.flush_enable  = 1'b1;
        bus.flush_address = 32'h300;
        tick(); exp_bub("flst", 32'h300);
        bus.stall        = 1'b0;
        bus.flush_enable = 1'b0;
        tick(); exp_dlv("flst_d", 32'h300, 32'h304);

        // Flush in HOLD drops the buffered word
        bus.stall = 1'b1;
        tick(); exp_hold("flh_hold", 32'h300);
        bus.flush_enable  = 1'b1;
        bus.flush_address = 32'h500;
        tick(); exp_bub("flh", 32'h500);
        bus.flush_enable = 1'b0;
        bus.stall        = 1'b0;
        tick(); exp_dlv("flh_d", 32'h500, 32'h504);

        // pc wraps at 2^32
        bus.flush_enable  = 1'b1;
        bus.flush_address = 32'hFFFF_FFFC;
        tick(); exp_bub("wrap_fl", 32'hFFFF_FFFC);
        bus.flush_enable = 1'b0;
        tick(); exp_dlv("wrap_d0", 32'hFFFF_FFFC, 32'h0);
        tick(); exp_dlv("wrap_d1", 32'h0, 32'h4);

        // Reset mid-request
        bus.rom_ready = 1'b0;
        tick(); exp_bub("rreq_wait", 32'h4);
        reset = 1'b1;
        tick(); exp_bub("rreq_rst", 32'h0);
        chk("rreq_rst.pc", bus.register_pc, 32'h0);
        reset         = 1'b0;
        bus.rom_ready = 1'b1;
        tick(); exp_dlv("rreq_d", 32'h0, 32'h4);

        // Reset mid-HOLD: buffered word for 0x4 must not appear
        bus.stall = 1'b1;
        tick(); exp_hold("rhold_hold", 32'h0);
        reset = 1'b1;
        tick(); exp_bub("rhold_rst", 32'h0);
        chk("rhold_rst.pc", bus.register_pc, 32'h0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        tick(); exp_dlv("rhold_d", 32'h0, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
